deserializer: RTL and testbench

- Receive-side counterpart of the team's serializer: collects a serial bit stream into WIDTH-bit words and presents each word on a valid/ready output interface.
- Sits at the far end of a serial link, after the bit has been sampled into the `clk` domain; feeds a word-wide consumer such as a FIFO or register file.
- An `in_start` marker aligns the start of each frame.
- Sticky status flags report dropped words (overrun) and broken frames (frame error).

---
 rtl/deserializer.sv | 105 ++++++++++
 tb/tb_deserializer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: gathers framed serial bits into WIDTH-bit words
// and offers them on a valid/ready interface with sticky overrun/frame-error flags.
module deserializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_start,
  output logic [WIDTH-1:0] out_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;

  logic [WIDTH-1:0] shifted_c;
  logic [WIDTH-1:0] first_c;
  logic             last_c;
  logic             restart_c;

  // Shift-in value, fresh-frame value, and frame event decode
  always_comb begin
    if (MSB_FIRST) begin
      shifted_c = {shreg[WIDTH-2:0], in_bit};
      first_c   = {{(WIDTH-1){1'b0}}, in_bit};
    end else begin
      shifted_c = {in_bit, shreg[WIDTH-1:1]};
      first_c   = {in_bit, {(WIDTH-1){1'b0}}};
    end
    last_c    = (state == SHIFT) && in_valid && !in_start && (cnt == CW'(WIDTH-1));
    restart_c = (state == SHIFT) && in_valid && in_start;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      out_value <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_start) begin
            shreg <= first_c;
            cnt   <= CW'(1);
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (in_valid) begin
            if (in_start) begin
              shreg <= first_c;
              cnt   <= CW'(1);
            end else if (last_c) begin
              shreg <= shifted_c;
              cnt   <= '0;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              shreg <= shifted_c;
              cnt   <= cnt + CW'(1);
            end
          end
        end
      endcase

      // A completed word loads only if the buffer is empty or draining now
      if (last_c) begin
        if (!out_valid || out_ready) begin
          out_value <= shifted_c;
          out_valid <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Clear first so a coincident set event takes priority
      if (clr_err) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (last_c && out_valid && !out_ready) overrun <= 1'b1;
      if (restart_c) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Randomized and directed bench for deserializer; MSB-first and LSB-first
// instances share one stimulus stream and are checked against a frame-level model.
module tb_deserializer;

  logic clk = 1'b0;
  logic rst_n, in_bit, in_valid, in_start, out_ready, clr_err;
  logic [7:0] val_m, val_l;
  logic valid_m, valid_l, busy_m, busy_l, ov_m, ov_l, fe_m, fe_l;

  int n_checks = 0;
  int n_fail   = 0;

  bit         q[$];
  logic       m_valid, m_ov, m_fe;
  logic [7:0] m_val_m, m_val_l;

  always #5 clk = ~clk;

  deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .in_start(in_start),
    .out_value(val_m), .out_valid(valid_m), .out_ready(out_ready), .busy(busy_m),
    .overrun(ov_m), .frame_err(fe_m), .clr_err(clr_err));

  deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid), .in_start(in_start),
    .out_value(val_l), .out_valid(valid_l), .out_ready(out_ready), .busy(busy_l),
    .overrun(ov_l), .frame_err(fe_l), .clr_err(clr_err));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: a list of received bits, composed into a word when full
  task automatic model_edge();
    logic complete, set_ov, set_fe, xfer;
    logic [7:0] wm, wl;
    complete = 1'b0; set_ov = 1'b0; set_fe = 1'b0; wm = '0; wl = '0;
    if (!rst_n) begin
      q.delete();
      m_valid = 1'b0; m_val_m = '0; m_val_l = '0; m_ov = 1'b0; m_fe = 1'b0;
      return;
    end
    if (in_valid) begin
      if (in_start) begin
        if (q.size() > 0) set_fe = 1'b1;
        q.delete();
        q.push_back(in_bit);
      end else if (q.size() > 0) begin
        q.push_back(in_bit);
        if (q.size() == 8) begin
          complete = 1'b1;
          for (int i = 0; i < 8; i++) begin
            wm = wm | (8'(q[i]) << (7 - i));
            wl = wl | (8'(q[i]) << i);
          end
          q.delete();
        end
      end
    end
    xfer = m_valid && out_ready;
    if (complete) begin
      if (!m_valid || out_ready) begin
        m_valid = 1'b1; m_val_m = wm; m_val_l = wl;
      end else begin
        set_ov = 1'b1;
      end
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    if (clr_err) begin m_ov = 1'b0; m_fe = 1'b0; end
    if (set_ov) m_ov = 1'b1;
    if (set_fe) m_fe = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("value_msb", 32'(val_m), 32'(m_val_m));
    check("value_lsb", 32'(val_l), 32'(m_val_l));
    check("valid_msb", 32'(valid_m), 32'(m_valid));
    check("valid_lsb", 32'(valid_l), 32'(m_valid));
    check("busy_msb", 32'(busy_m), 32'(q.size() > 0));
    check("busy_lsb", 32'(busy_l), 32'(q.size() > 0));
    check("overrun_msb", 32'(ov_m), 32'(m_ov));
    check("overrun_lsb", 32'(ov_l), 32'(m_ov));
    check("frame_err_msb", 32'(fe_m), 32'(m_fe));
    check("frame_err_lsb", 32'(fe_l), 32'(m_fe));
  endtask

  task automatic send_bit(input logic b, input logic s);
    in_valid = 1'b1; in_bit = b; in_start = s;
    step();
    in_valid = 1'b0; in_start = 1'b0; clr_err = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Sends w first-bit-first as the MSB-first instance sees it
  task automatic send_frame(input logic [7:0] w, input int max_gap,
                            input logic clr_first, input logic rdy_last);
    for (int i = 7; i >= 0; i--) begin
      if (i == 7 && clr_first) clr_err = 1'b1;
      if (i == 0 && rdy_last) out_ready = 1'b1;
      send_bit(w[i], 1'(i == 7));
      if (max_gap > 0 && i > 0) idle($urandom_range(1, max_gap));
    end
  endtask

  initial begin
    rst_n = 1'b0; in_bit = 1'b0; in_valid = 1'b0; in_start = 1'b0;
    out_ready = 1'b1; clr_err = 1'b0;
    idle(2);
    check("reset_valid", 32'(valid_m), 32'd0);
    check("reset_value", 32'(val_m), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Back-to-back-bit frame
    send_frame(8'hA5, 0, 1'b0, 1'b0);
    check("t1_value", 32'(val_m), 32'hA5);
    check("t1_valid", 32'(valid_m), 32'd1);
    idle(1);
    check("t1_valid_drop", 32'(valid_m), 32'd0);

    // Stray idle bits then a gapped frame; then bit-order comparison
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_frame(8'hA5, 3, 1'b0, 1'b0);
    check("t2_value", 32'(val_m), 32'hA5);
    send_frame(8'hC0, 0, 1'b0, 1'b0);
    check("t2_msb", 32'(val_m), 32'hC0);
    check("t2_lsb", 32'(val_l), 32'h03);
    idle(2);

    // Overrun with a stalled consumer
    out_ready = 1'b0;
    send_frame(8'h3C, 0, 1'b0, 1'b0);
    send_frame(8'hFF, 0, 1'b0, 1'b0);
    check("t3_hold", 32'(val_m), 32'h3C);
    check("t3_ov", 32'(ov_m), 32'd1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check("t3_clr", 32'(ov_m), 32'd0);
    out_ready = 1'b1; step();
    check("t3_drained", 32'(valid_m), 32'd0);
    idle(1);

    // Mid-frame restart, then restart coinciding with clr_err
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_frame(8'h81, 0, 1'b0, 1'b0);
    check("t4_value", 32'(val_m), 32'h81);
    check("t4_fe", 32'(fe_m), 32'd1);
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    send_frame(8'h81, 0, 1'b1, 1'b0);
    check("t4_set_wins", 32'(fe_m), 32'd1);
    clr_err = 1'b1; step(); clr_err = 1'b0;

    // Completion on the same edge the buffer drains
    out_ready = 1'b0;
    send_frame(8'h11, 0, 1'b0, 1'b0);
    send_frame(8'h22, 0, 1'b0, 1'b1);
    check("t5_value", 32'(val_m), 32'h22);
    check("t5_valid", 32'(valid_m), 32'd1);
    check("t5_ov", 32'(ov_m), 32'd0);
    idle(2);

    // Reset mid-frame, then a clean frame
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("t6_busy", 32'(busy_m), 32'd0);
    check("t6_value", 32'(val_m), 32'd0);
    send_frame(8'h5A, 0, 1'b0, 1'b0);
    check("t6_frame", 32'(val_m), 32'h5A);
    check("t6_fe", 32'(fe_m), 32'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_start  = in_valid && ($urandom_range(0, 11) == 0);
      in_bit    = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_err   = ($urandom_range(0, 39) == 0);
      rst_n     = ($urandom_range(0, 599) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
